// File: rtl/sd_uart_dumper.sv
// sd_uart_dumper: buffers SD file bytes in a FIFO and streams them over an 8N1 UART, raw or as an ASCII hex dump
// Ports: clk/rst (async, active-high); wreq/wdata byte strobe; eof end-of-file pulse;
//        o_uart_tx serial line; fifo_full, overflow (sticky drop), byte_count (accepted bytes), busy.
module sd_uart_dumper #(
  parameter int CLK_DIV        = 868,
  parameter int FIFO_ASIZE     = 10,
  parameter int MODE           = 0,
  parameter int BYTES_PER_LINE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wreq,
  input  logic [7:0]  wdata,
  input  logic        eof,
  output logic        o_uart_tx,
  output logic        fifo_full,
  output logic        overflow,
  output logic [31:0] byte_count,
  output logic        busy
);
  localparam int BIT = 2 * CLK_DIV;
  localparam int CW  = $clog2(BIT);
  localparam int PW  = FIFO_ASIZE + 1;
  typedef enum logic [1:0] {IDLE, FETCH, EMIT, WAIT_TX} state_t;
  state_t state, state_n;
  logic [7:0] mem [2**FIFO_ASIZE];
  logic [PW-1:0] wptr, rptr;
  logic empty, push, pop, load, flush, eof_clr, eof_lat, last;
  logic [7:0] rdata, k, k_n, ch;
  logic [3:0][7:0] seq, seq_n;
  logic [2:0] len, len_n, idx;
  logic tx_busy, tx_stop, tx_last;
  logic [8:0] sh;
  logic [3:0] bit_cnt;
  logic [CW-1:0] cnt;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  assign empty     = wptr == rptr;
  assign fifo_full = (wptr[FIFO_ASIZE] != rptr[FIFO_ASIZE]) && (wptr[FIFO_ASIZE-1:0] == rptr[FIFO_ASIZE-1:0]);
  assign push      = wreq && !fifo_full;
  assign rdata     = mem[rptr[FIFO_ASIZE-1:0]];
  assign busy      = !empty || state != IDLE || tx_busy;
  assign ch        = seq[idx[1:0]];
  assign tx_stop   = tx_busy && bit_cnt == 4'd9;
  assign tx_last   = tx_stop && cnt == CW'(BIT - 1);

  always_ff @(posedge clk)
    if (push) mem[wptr[FIFO_ASIZE-1:0]] <= wdata;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      overflow   <= 1'b0;
      byte_count <= '0;
    end else begin
      if (push) begin
        wptr       <= wptr + PW'(1);
        byte_count <= byte_count + 32'd1;
      end
      if (pop) rptr <= rptr + PW'(1);
      if (wreq && fifo_full) overflow <= 1'b1;
    end

  // seq[0] is sent first; a full line ends in CR LF instead of a space
  always_comb begin
    last  = k >= 8'(BYTES_PER_LINE - 1);
    seq_n = MODE == 0 ? {24'h0, rdata} : {last ? 16'h0A0D : 16'h0020, hex(rdata[3:0]), hex(rdata[7:4])};
    len_n = MODE == 0 ? 3'd1 : last ? 3'd4 : 3'd3;
    k_n   = last ? 8'd0 : k + 8'd1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;

  // WAIT_TX releases as soon as the stop bit starts so the next character can be
  // prepared and loaded on the very edge the stop bit ends (no inter-frame gap)
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    load    = 1'b0;
    flush   = 1'b0;
    eof_clr = 1'b0;
    case (state)
      IDLE:
        if (!empty) state_n = FETCH;
        else if (eof_lat) begin
          eof_clr = 1'b1;
          flush   = k != 8'd0;
          state_n = k != 8'd0 ? EMIT : IDLE;
        end
      FETCH: begin
        pop     = 1'b1;
        state_n = EMIT;
      end
      EMIT:
        if (!tx_busy || tx_last) begin
          load    = 1'b1;
          state_n = WAIT_TX;
        end
      WAIT_TX: if (tx_stop) state_n = idx == len ? IDLE : EMIT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      seq     <= '0;
      len     <= '0;
      idx     <= '0;
      k       <= '0;
      eof_lat <= 1'b0;
    end else begin
      if (pop) begin
        seq <= seq_n;
        len <= len_n;
        idx <= '0;
        k   <= k_n;
      end else if (flush) begin
        seq <= 32'h0000_0A0D;
        len <= 3'd2;
        idx <= '0;
        k   <= '0;
      end
      if (load) idx <= idx + 3'd1;
      eof_lat <= (MODE == 1 && eof) || (eof_lat && !eof_clr);
    end

  // sh holds the remaining data bits plus the stop bit; ones shift in behind it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      o_uart_tx <= 1'b1;
      tx_busy   <= 1'b0;
      sh        <= '1;
      bit_cnt   <= '0;
      cnt       <= '0;
    end else if (load) begin
      o_uart_tx <= 1'b0;
      tx_busy   <= 1'b1;
      sh        <= {1'b1, ch};
      bit_cnt   <= '0;
      cnt       <= '0;
    end else if (tx_busy) begin
      if (cnt == CW'(BIT - 1)) begin
        cnt       <= '0;
        bit_cnt   <= bit_cnt + 4'd1;
        o_uart_tx <= sh[0];
        sh        <= {1'b1, sh[8:1]};
        tx_busy   <= bit_cnt != 4'd9;
      end else cnt <= cnt + CW'(1);
    end
endmodule

// File: tb/tb_sd_uart_dumper.sv
// tb_sd_uart_dumper: directed checks of raw and hex-dump UART output, overflow, eof and reset behaviour
module tb_sd_uart_dumper;
  logic clk = 1'b0, rst = 1'b0;
  logic wreq0 = 1'b0, eof0 = 1'b0, wreq1 = 1'b0, eof1 = 1'b0;
  logic [7:0] wdata0 = 8'h0, wdata1 = 8'h0;
  logic tx0, full0, ovf0, busy0, tx1, full1, ovf1, busy1;
  logic [31:0] cnt0, cnt1;
  logic [1:0] txv;
  logic [7:0] q0[$], q1[$];
  int n_chk = 0, n_err = 0, lows;
  logic [7:0] hb3 [3]  = '{8'hA5, 8'h3C, 8'h0F};
  logic [7:0] e3  [12] = '{8'h41, 8'h35, 8'h20, 8'h33, 8'h43, 8'h0D, 8'h0A, 8'h30, 8'h46, 8'h20, 8'h0D, 8'h0A};
  logic [7:0] e4  [7]  = '{8'h30, 8'h30, 8'h20, 8'h46, 8'h46, 8'h0D, 8'h0A};

  always #5 clk = ~clk;

  sd_uart_dumper #(.CLK_DIV(4), .FIFO_ASIZE(2), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .wreq(wreq0), .wdata(wdata0), .eof(eof0), .o_uart_tx(tx0),
    .fifo_full(full0), .overflow(ovf0), .byte_count(cnt0), .busy(busy0));
  sd_uart_dumper #(.CLK_DIV(4), .FIFO_ASIZE(2), .MODE(1), .BYTES_PER_LINE(2)) u1 (
    .clk(clk), .rst(rst), .wreq(wreq1), .wdata(wdata1), .eof(eof1), .o_uart_tx(tx1),
    .fifo_full(full1), .overflow(ovf1), .byte_count(cnt1), .busy(busy1));

  assign txv = {tx1, tx0};

  // UART receivers: sample mid-bit (bit period 8 cycles); frames touched by reset are discarded
  for (genvar g = 0; g < 2; g++) begin : mon
    initial begin
      logic [7:0] b;
      logic bad;
      forever begin
        @(negedge clk);
        if (!rst && txv[g] == 1'b0) begin
          bad = 1'b0;
          b = 8'h0;
          repeat (3) begin @(negedge clk); bad |= rst; end
          bad |= txv[g];
          for (int i = 0; i < 8; i++) begin
            repeat (8) begin @(negedge clk); bad |= rst; end
            b[i] = txv[g];
          end
          repeat (8) begin @(negedge clk); bad |= rst; end
          bad |= ~txv[g];
          if (!bad) begin
            if (g == 0) q0.push_back(b);
            else q1.push_back(b);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q(input int which, input int n, input int budget);
    int t = 0;
    while ((which != 0 ? q1.size() : q0.size()) < n && t < budget) begin step(); t++; end
    chk($sformatf("rx_count%0d", which), which != 0 ? q1.size() : q0.size(), n);
  endtask

  task automatic wait_idle(input int which, input int budget);
    int t = 0;
    while ((which != 0 ? busy1 : busy0) && t < budget) begin step(); t++; end
    chk($sformatf("idle%0d", which), which != 0 ? busy1 : busy0, 0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_tx0", tx0, 1); chk("rst_full0", full0, 0); chk("rst_ovf0", ovf0, 0);
    chk("rst_cnt0", cnt0, 0); chk("rst_busy0", busy0, 0); chk("rst_tx1", tx1, 1); chk("rst_busy1", busy1, 0);
    step(); step();
    rst = 1'b0;
    step();
    // raw byte 0x55: start falls 3 edges after acceptance, 8 cycles per bit
    wreq0 = 1'b1; wdata0 = 8'h55;
    step();
    wreq0 = 1'b0;
    chk("cnt_55", cnt0, 1); chk("busy_55", busy0, 1); chk("tx_n0", tx0, 1);
    step(); chk("tx_n1", tx0, 1);
    step(); chk("tx_n2", tx0, 1);
    step(); chk("tx_n3_fall", tx0, 0);
    repeat (7) step(); chk("start_last_cycle", tx0, 0);
    step(); chk("bit0", tx0, 1);
    repeat (8) step(); chk("bit1", tx0, 0);
    repeat (8) step(); chk("bit2", tx0, 1);
    wait_q(0, 1, 500);
    chk("rx_55", q0[0], 8'h55);
    wait_idle(0, 500);
    // 6 back-to-back writes into a 4-deep FIFO: one pop happens, 6th byte dropped
    for (int i = 0; i < 6; i++) begin
      wreq0 = 1'b1; wdata0 = 8'(8'h11 + i);
      step();
      if (i == 3) chk("full_at3", full0, 0);
      if (i == 4) begin chk("full_at4", full0, 1); chk("ovf_at4", ovf0, 0); end
    end
    wreq0 = 1'b0;
    chk("ovf_set", ovf0, 1); chk("full_held", full0, 1); chk("cnt_ovf", cnt0, 6);
    wait_q(0, 6, 3000);
    for (int i = 1; i < 6; i++) chk($sformatf("rx_ovf%0d", i), q0[i], 32'(8'h10 + i));
    wait_idle(0, 3000);
    repeat (100) step();
    chk("no_dropped_byte", q0.size(), 6);
    // hex dump, 2 bytes per line, eof mid-line adds CR LF
    for (int i = 0; i < 3; i++) begin
      wreq1 = 1'b1; wdata1 = hb3[i];
      step();
    end
    wreq1 = 1'b0; eof1 = 1'b1;
    step();
    eof1 = 1'b0;
    chk("cnt_hex", cnt1, 3); chk("ovf_hex", ovf1, 0); chk("full_hex", full1, 0);
    wait_q(1, 12, 4000);
    for (int i = 0; i < 12; i++) chk($sformatf("hex_char%0d", i), q1[i], e3[i]);
    wait_idle(1, 500);
    // exactly one full line then eof: no extra CR LF, busy drops at end of last stop bit
    wreq1 = 1'b1; wdata1 = 8'h00; step();
    wdata1 = 8'hFF; step();
    wreq1 = 1'b0; eof1 = 1'b1; step();
    eof1 = 1'b0;
    wait_q(1, 19, 4000);
    chk("busy_in_last_stop", busy1, 1);
    repeat (6) step();
    chk("busy_after_stop", busy1, 0);
    for (int i = 0; i < 7; i++) chk($sformatf("line_char%0d", i), q1[12 + i], e4[i]);
    repeat (200) step();
    chk("no_extra_crlf", q1.size(), 19);
    // reset in a data bit of the second of three queued frames
    for (int i = 0; i < 3; i++) begin
      wreq0 = 1'b1; wdata0 = 8'(8'hA1 + i);
      step();
    end
    wreq0 = 1'b0;
    wait_q(0, 7, 2000);
    chk("rx_A1", q0[6], 8'hA1);
    repeat (20) step();
    chk("busy_mid_frame2", busy0, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_tx0", tx0, 1); chk("arst_busy0", busy0, 0); chk("arst_cnt0", cnt0, 0);
    chk("arst_ovf0", ovf0, 0); chk("arst_full0", full0, 0); chk("arst_cnt1", cnt1, 0);
    step();
    rst = 1'b0;
    lows = 0;
    repeat (300) begin step(); if (!tx0) lows++; end
    chk("no_tx_after_rst", lows, 0); chk("rx_after_rst", q0.size(), 7); chk("idle_after_rst", busy0, 0);
    // byte presented across reset release is taken on the first free edge
    rst = 1'b1; wreq0 = 1'b1; wdata0 = 8'h5A;
    step();
    chk("cnt_in_rst", cnt0, 0);
    rst = 1'b0;
    step();
    wreq0 = 1'b0;
    chk("cnt_first_edge", cnt0, 1);
    wait_q(0, 8, 500);
    chk("rx_5A", q0[7], 8'h5A);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
